// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types, rotation constants and per-step decode for the ChaCha quarter-round sequencer
package chacha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] ROT16 = 5'd16;
    localparam logic [4:0] ROT12 = 5'd12;
    localparam logic [4:0] ROT8  = 5'd8;
    localparam logic [4:0] ROT7  = 5'd7;

    localparam logic [1:0] W_A = 2'd0;
    localparam logic [1:0] W_B = 2'd1;
    localparam logic [1:0] W_C = 2'd2;
    localparam logic [1:0] W_D = 2'd3;

    // Tables are in forward order; inverse step k undoes forward step 7-k.
    localparam logic [7:0][1:0] FWD_TGT   = {W_B, W_C, W_D, W_A, W_B, W_C, W_D, W_A};
    localparam logic [7:0][1:0] FWD_SRC   = {W_C, W_D, W_A, W_B, W_C, W_D, W_A, W_B};
    localparam logic [7:0]      FWD_ARITH = 8'b0101_0101;
    localparam logic [7:0][4:0] FWD_ROT   = {ROT7, 5'd0, ROT8, 5'd0, ROT12, 5'd0, ROT16, 5'd0};

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] r);
        return (x << r) | (x >> (6'd32 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/chacha_iqr_seq_if.sv
// rtl/chacha_iqr_seq_if.sv - operand/result handshake bundle for chacha_iqr_seq
interface chacha_iqr_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_op_fwd;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] rd_ad;
    logic [63:0] rd_bc;

    modport master (
        output in_valid, in_op_fwd, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd_ad, rd_bc
    );

    modport slave (
        input  in_valid, in_op_fwd, rs1, rs2, out_ready,
        output in_ready, out_valid, rd_ad, rd_bc
    );

endinterface

// File: rtl/chacha_qr_step.sv
// rtl/chacha_qr_step.sv - one combinational quarter-round micro-step; forward slice under CHACHA_IQR_FWD_EN
module chacha_qr_step
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [2:0]  step_i,
    input  logic        op_fwd_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [3:0][31:0] words;
    logic [2:0]       idx;
    logic             fwd;
    logic [1:0]       tgt;
    logic [1:0]       src;
    logic [4:0]       rot;
    logic [31:0]      t;
    logic [31:0]      s;
    logic [31:0]      res;

`ifdef CHACHA_IQR_FWD_EN
    assign fwd = op_fwd_i;
`else
    logic unused_op_fwd;
    assign unused_op_fwd = op_fwd_i;
    assign fwd = 1'b0;
`endif

    assign words = {d_i, c_i, b_i, a_i};
    assign idx   = fwd ? step_i : ~step_i;
    assign tgt   = FWD_TGT[idx];
    assign src   = FWD_SRC[idx];
    assign rot   = FWD_ROT[idx];
    assign t     = words[tgt];
    assign s     = words[src];

    always_comb begin
        res = t;
`ifdef CHACHA_IQR_FWD_EN
        if (FWD_ARITH[idx]) begin
            res = fwd ? (t + s) : (t - s);
        end else begin
            res = fwd ? rotl32(t ^ s, rot) : (rotr32(t, rot) ^ s);
        end
`else
        if (FWD_ARITH[idx]) begin
            res = t - s;
        end else begin
            res = rotr32(t, rot) ^ s;
        end
`endif
    end

    assign a_o = (tgt == W_A) ? res : a_i;
    assign b_o = (tgt == W_B) ? res : b_i;
    assign c_o = (tgt == W_C) ? res : c_i;
    assign d_o = (tgt == W_D) ? res : d_i;

endmodule

// File: rtl/chacha_iqr_seq.sv
// rtl/chacha_iqr_seq.sv - iterative inverse ChaCha quarter-round over valid/ready; forward mode under CHACHA_IQR_FWD_EN
module chacha_iqr_seq
    import chacha_pkg::*;
(
    input  logic              g_clk,
    input  logic              g_resetn,
    chacha_iqr_seq_if.slave   bus
);

    state_e      state_q, state_d;
    logic [31:0] a_q, b_q, c_q, d_q;
    logic [31:0] a_d, b_d, c_d, d_d;
    logic [31:0] a_nx, b_nx, c_nx, d_nx;
    logic [2:0]  step_q, step_d;
    logic        op_fwd_q, op_fwd_d;
    logic        accept;
    logic        fwd_in;

`ifdef CHACHA_IQR_FWD_EN
    assign fwd_in = bus.in_op_fwd;
`else
    logic unused_in_op_fwd;
    assign unused_in_op_fwd = bus.in_op_fwd;
    assign fwd_in = 1'b0;
`endif

    chacha_qr_step u_step (
        .a_i      (a_q),
        .b_i      (b_q),
        .c_i      (c_q),
        .d_i      (d_q),
        .step_i   (step_q),
        .op_fwd_i (op_fwd_q),
        .a_o      (a_nx),
        .b_o      (b_nx),
        .c_o      (c_nx),
        .d_o      (d_nx)
    );

    // Ready in DONE only once the held result is being taken.
    assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.rd_ad     = {a_q, d_q};
    assign bus.rd_bc     = {b_q, c_q};
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        step_d   = step_q;
        op_fwd_d = op_fwd_q;
        case (state_q)
            ST_RUN: begin
                a_d    = a_nx;
                b_d    = b_nx;
                c_d    = c_nx;
                d_d    = d_nx;
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            a_d      = bus.rs1[63:32];
            d_d      = bus.rs1[31:0];
            b_d      = bus.rs2[63:32];
            c_d      = bus.rs2[31:0];
            op_fwd_d = fwd_in;
            step_d   = 3'd0;
            state_d  = ST_RUN;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q  <= ST_IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            c_q      <= 32'd0;
            d_q      <= 32'd0;
            step_q   <= 3'd0;
            op_fwd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            step_q   <= step_d;
            op_fwd_q <= op_fwd_d;
        end
    end

endmodule
